// File: rtl/llc_mem_arbiter.sv
// llc_mem_arbiter: two-requester (I-side / D-side) cacheline arbiter in front
// of a single cacheline adaptor port. One transaction in flight at a time;
// the winner's command is latched on grant and replayed to memory until
// mmem_resp, followed by a one-cycle RECOVER gap.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate on simultaneous
// requests). Without it, the D side has fixed priority.
module llc_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic              imem_write,
  input  logic [ADDR_W-1:0] imem_address,
  input  logic [LINE_W-1:0] imem_wdata,
  output logic [LINE_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [LINE_W-1:0] dmem_wdata,
  output logic [LINE_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              mmem_read,
  output logic              mmem_write,
  output logic [ADDR_W-1:0] mmem_address,
  output logic [LINE_W-1:0] mmem_wdata,
  input  logic [LINE_W-1:0] mmem_rdata,
  input  logic              mmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic              req_i;
  logic              req_d;
  logic              pick_d;
  logic              grant_now;
  logic              cmd_read;
  logic              cmd_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [15:0]       icount;
  logic [15:0]       dcount;

  assign req_i     = imem_read | imem_write;
  assign req_d     = dmem_read | dmem_write;
  assign grant_now = (state == IDLE) && (req_i || req_d);

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = I side was granted last, 1 = D side
  logic last_grant;

  // On a tie the side that did not win last time takes the grant
  assign pick_d = req_d & (~req_i | ~last_grant);

  // Remember which side won each grant
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b0;
    else if (grant_now)
      last_grant <= pick_d;
  end
`else
  // D side always wins a tie
  assign pick_d = req_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state decode: arbitrate in IDLE, wait for resp, one recovery cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_i || req_d)
          state_next = pick_d ? GRANT_D : GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (mmem_resp)
          state_next = RECOVER;
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's command on grant; drop the command when memory answers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (grant_now) begin
      addr_q  <= pick_d ? dmem_address : imem_address;
      wdata_q <= pick_d ? dmem_wdata : imem_wdata;
      // a simultaneous read+write is treated purely as a write
      cmd_write <= pick_d ? dmem_write : imem_write;
      cmd_read  <= pick_d ? (dmem_read & ~dmem_write) : (imem_read & ~imem_write);
    end else if ((state == GRANT_I || state == GRANT_D) && mmem_resp) begin
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
    end
  end

  assign mmem_read    = cmd_read;
  assign mmem_write   = cmd_write;
  assign mmem_address = addr_q;
  assign mmem_wdata   = wdata_q;

  // Completion is passed straight through to the granted side; a reset in the
  // same cycle suppresses it so an abandoned transaction never completes
  assign imem_resp  = (state == GRANT_I) && mmem_resp && !rst;
  assign dmem_resp  = (state == GRANT_D) && mmem_resp && !rst;
  assign imem_rdata = mmem_rdata;
  assign dmem_rdata = mmem_rdata;

  // Saturating per-side completion counters
  always_ff @(posedge clk) begin
    if (rst) begin
      icount <= 16'd0;
      dcount <= 16'd0;
    end else begin
      if (imem_resp && icount != 16'hFFFF)
        icount <= icount + 16'd1;
      if (dmem_resp && dcount != 16'hFFFF)
        dcount <= dcount + 16'd1;
    end
  end

endmodule

// File: tb/tb_llc_mem_arbiter.sv
// tb_llc_mem_arbiter: directed and randomized transactions against
// llc_mem_arbiter; the bench plays both requesters and the memory side.
// Build with ARB_ROUND_ROBIN_EN to check the alternating arbitration mode.
module tb_llc_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ir, iw, dr, dw;
  logic [31:0]  ia, da;
  logic [255:0] iwd, dwd;
  logic [255:0] ird, drd;
  logic         iresp, dresp;
  logic         mr, mw;
  logic [31:0]  ma;
  logic [255:0] mwd, mrd;
  logic         mresp;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_last_d = 1'b0;
  int m_icnt   = 0;
  int m_dcnt   = 0;

  llc_mem_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_read(ir), .imem_write(iw), .imem_address(ia), .imem_wdata(iwd),
    .imem_rdata(ird), .imem_resp(iresp),
    .dmem_read(dr), .dmem_write(dw), .dmem_address(da), .dmem_wdata(dwd),
    .dmem_rdata(drd), .dmem_resp(dresp),
    .mmem_read(mr), .mmem_write(mw), .mmem_address(ma), .mmem_wdata(mwd),
    .mmem_rdata(mrd), .mmem_resp(mresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference arbitration rule: 1 means the D side wins
  function automatic bit model_pick_d(input bit i_req, input bit d_req);
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) return !m_last_d;
    return d_req;
`else
    return d_req;
`endif
  endfunction

  // Wait for the command, check it, hold for lat cycles, answer, check recovery
  task automatic serve(input bit sd, input bit sw, input logic [31:0] ea,
                       input logic [255:0] ewd, input int lat, input int exp_wait,
                       input bit late_en, input bit late_w, input logic [31:0] late_a);
    int n;
    logic [255:0] rd;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(mr || mw) && n < 12);
    chk("grant_latency", 256'(n), 256'(exp_wait));
    if (!(mr || mw)) return;
    chk("mmem_write", 256'(mw), 256'(sw));
    chk("mmem_read", 256'(mr), 256'(!sw));
    chk("mmem_address", 256'(ma), 256'(ea));
    chk("mmem_wdata", mwd, ewd);
    m_last_d = sd;
    if (late_en) begin
      if (sd) begin ir = !late_w; iw = late_w; ia = late_a; end
      else    begin dr = !late_w; dw = late_w; da = late_a; end
    end
    for (int i = 1; i < lat; i++) begin
      if (sd) begin da = $urandom(); dwd = rand_line(); end
      else    begin ia = $urandom(); iwd = rand_line(); end
      @(negedge clk); #1;
      chk("hold_address", 256'(ma), 256'(ea));
      chk("hold_wdata", mwd, ewd);
      chk("hold_cmd", 256'({mw, mr}), 256'({sw, !sw}));
      chk("early_resp", 256'({iresp, dresp}), 256'(0));
    end
    rd = rand_line();
    mrd = rd;
    mresp = 1'b1;
    #1;
    chk("imem_resp", 256'(iresp), 256'(!sd));
    chk("dmem_resp", 256'(dresp), 256'(sd));
    chk("rdata", sd ? drd : ird, rd);
    if (sd) m_dcnt++; else m_icnt++;
    if (sd) begin dr = 1'b0; dw = 1'b0; end
    else    begin ir = 1'b0; iw = 1'b0; end
    @(negedge clk);
    mresp = 1'b0;
    #1;
    chk("recover_cmd", 256'({mw, mr}), 256'(0));
    chk("icount", 256'(dut.icount), 256'(16'(m_icnt)));
    chk("dcount", 256'(dut.dcount), 256'(16'(m_dcnt)));
  endtask

  // Present requests on both sides (op = {write, read}) and serve them in model order
  task automatic run(input logic [1:0] iop, input logic [31:0] ia_,
                     input logic [1:0] dop, input logic [31:0] da_, input int lat);
    bit i_req, d_req, first_d;
    logic [255:0] iw_line, dw_line;
    iw_line = rand_line();
    dw_line = rand_line();
    ir = iop[0]; iw = iop[1]; ia = ia_; iwd = iw_line;
    dr = dop[0]; dw = dop[1]; da = da_; dwd = dw_line;
    i_req = |iop;
    d_req = |dop;
    first_d = model_pick_d(i_req, d_req);
    if (first_d) serve(1'b1, dop[1], da_, dw_line, lat, 1, 1'b0, 1'b0, 32'h0);
    else         serve(1'b0, iop[1], ia_, iw_line, lat, 1, 1'b0, 1'b0, 32'h0);
    if (i_req && d_req) begin
      if (first_d) serve(1'b0, iop[1], ia_, iw_line, lat, 2, 1'b0, 1'b0, 32'h0);
      else         serve(1'b1, dop[1], da_, dw_line, lat, 2, 1'b0, 1'b0, 32'h0);
    end
    @(negedge clk); #1;
    chk("idle_cmd", 256'({mw, mr}), 256'(0));
  endtask

  initial begin
    logic [255:0] pat;
    logic [255:0] line_d;
    int n;
    rst = 1'b1; ir = 0; iw = 0; dr = 0; dw = 0; ia = 0; da = 0;
    iwd = '0; dwd = '0; mrd = '0; mresp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd", 256'({mw, mr}), 256'(0));
    chk("rst_address", 256'(ma), 256'(0));
    chk("rst_wdata", mwd, 256'(0));
    chk("rst_resp", 256'({iresp, dresp}), 256'(0));
    chk("rst_icount", 256'(dut.icount), 256'(0));
    chk("rst_dcount", 256'(dut.dcount), 256'(0));
    rst = 1'b0;
    @(negedge clk); #1;

    // single I read, memory answers after 4 cycles
    run(2'b01, 32'h0000_0040, 2'b00, 32'h0, 4);

    // D write of the A5 pattern line
    pat = {32{8'hA5}};
    dw = 1'b1; dr = 1'b0; da = 32'h0000_1000; dwd = pat;
    serve(1'b1, 1'b1, 32'h0000_1000, pat, 5, 1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("idle_cmd", 256'({mw, mr}), 256'(0));

    // D read whose address moves to 0x2000 during the grant
    dr = 1'b1; da = 32'h0000_1000; line_d = dwd;
    fork
      begin
        repeat (2) @(negedge clk);
        da = 32'h0000_2000;
      end
    join_none
    serve(1'b1, 1'b0, 32'h0000_1000, line_d, 4, 1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;

    // simultaneous I and D reads, twice
    run(2'b01, 32'h0000_0100, 2'b01, 32'h0000_0200, 3);
    run(2'b01, 32'h0000_0140, 2'b01, 32'h0000_0240, 2);

    // read and write together is served as a write
    run(2'b11, 32'h0000_0080, 2'b00, 32'h0, 3);
    run(2'b00, 32'h0, 2'b11, 32'h0000_0080, 1);

    // D request arriving while I is granted waits for the next IDLE
    ir = 1'b1; iw = 1'b0; ia = 32'h0000_0300; pat = rand_line(); iwd = pat;
    line_d = dwd;
    serve(1'b0, 1'b0, 32'h0000_0300, pat, 3, 1, 1'b1, 1'b0, 32'h0000_0400);
    serve(1'b1, 1'b0, 32'h0000_0400, line_d, 2, 2, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;

    // reset in the second cycle of GRANT_I abandons the transaction
    ir = 1'b1; iw = 1'b0; ia = 32'h0000_0500;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!mr && n < 12);
    chk("pre_rst_grant", 256'(mr), 256'(1));
    @(negedge clk);
    rst = 1'b1; ir = 1'b0;
    #1;
    chk("rst_no_resp", 256'(iresp), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd", 256'({mw, mr}), 256'(0));
    chk("post_rst_address", 256'(ma), 256'(0));
    chk("post_rst_resp", 256'(iresp), 256'(0));
    m_last_d = 1'b0; m_icnt = 0; m_dcnt = 0;
    chk("post_rst_icount", 256'(dut.icount), 256'(0));
    @(negedge clk); #1;
    chk("post_rst_idle", 256'({mw, mr}), 256'(0));
    run(2'b01, 32'h0000_0600, 2'b00, 32'h0, 2);

    // randomized mix of lone and simultaneous requests
    for (int it = 0; it < 40; it++) begin
      logic [1:0] iop, dop;
      int gap;
      iop = 2'($urandom_range(0, 3));
      dop = 2'($urandom_range(0, 3));
      if (iop == 2'b00 && dop == 2'b00) iop = 2'b01;
      run(iop, {$urandom_range(0, 65535), 6'b0} & 32'h03FF_FFC0,
          dop, {$urandom_range(0, 65535), 6'b0} & 32'h03FF_FFC0,
          $urandom_range(1, 5));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); #1;
        chk("gap_idle", 256'({mw, mr}), 256'(0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
